// File: rtl/trng_pkg.sv
// Shared types and default sizing for the TRNG harvester slice.
package trng_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } asm_state_e;

  localparam int TRNG_WIDTH = 8;
  localparam int TRNG_DEPTH = 4;
  localparam int TRNG_DECIM = 4;

endpackage

// File: rtl/trng_fifo.sv
// First-word-fall-through word FIFO with flush; head reads as 0 when empty.
module trng_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_dat,
  output logic [WIDTH-1:0]           o_dat,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign do_pop  = i_pop & o_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
  assign do_push = i_push & ((o_level != LW'(DEPTH)) | do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      wptr    <= '0;
      rptr    <= '0;
      o_level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   o_level <= o_level + LW'(1);
        2'b01:   o_level <= o_level - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wptr] <= i_dat;
  end

  assign o_valid = (o_level != '0);
  assign o_dat   = o_valid ? mem[rptr] : '0;

endmodule

// File: rtl/trng_harvester.sv
// TRNG back end: sample/XOR rings, decimate, assemble words, buffer in FIFO.
// Optional repetition-count health test enabled by defining TRNG_HEALTH_EN.
module trng_harvester import trng_pkg::*; #(
  parameter int WIDTH      = TRNG_WIDTH,
  parameter int NSRC       = 4,
  parameter int SRC_WIDTH  = 3,
  parameter int DECIM      = TRNG_DECIM,
  parameter int DEPTH      = TRNG_DEPTH,
  parameter int RCT_CUTOFF = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [NSRC*SRC_WIDTH-1:0]   i_rnd_src,
  input  logic                        i_enable,
  input  logic                        i_read,
  output logic [WIDTH-1:0]            o_dat,
  output logic                        o_valid,
  output logic [$clog2(DEPTH+1)-1:0]  o_level,
  output logic [NSRC*SRC_WIDTH-1:0]   o_sampled,
  output logic                        o_alarm
);
  localparam int SW = NSRC*SRC_WIDTH;
  localparam int LW = $clog2(DEPTH+1);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int BW = $clog2(WIDTH);

  logic          alarm, alarm_set, kill;

  // Two-flop capture of the unsynchronised rings, then XOR fold to one raw bit.
  logic [SW-1:0] s1;
  logic          raw;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s1        <= '0;
      o_sampled <= '0;
      raw       <= 1'b0;
    end else begin
      s1        <= i_rnd_src;
      o_sampled <= s1;
      raw       <= ^o_sampled;
    end
  end

  logic [DW-1:0] dcnt;
  logic          acc, bit_vld, bit_val;
  assign bit_vld = i_enable & (dcnt == DW'(DECIM-1));
  assign bit_val = acc ^ raw;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || kill) begin
      dcnt <= '0;
      acc  <= 1'b0;
    end else if (i_enable) begin
      if (bit_vld) begin
        dcnt <= '0;
        acc  <= 1'b0;
      end else begin
        dcnt <= dcnt + DW'(1);
        acc  <= acc ^ raw;
      end
    end
  end

  asm_state_e       state, state_nxt;
  logic [WIDTH-1:0] word, word_nxt, push_dat;
  logic [BW-1:0]    bcnt, bcnt_nxt;
  logic             push_req, pop, space;

  assign pop   = i_read & o_valid;
  assign space = (o_level < LW'(DEPTH)) | pop;

  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    bcnt_nxt  = bcnt;
    push_req  = 1'b0;
    push_dat  = word;
    if (i_enable) begin
      case (state)
        ST_FILL: if (bit_vld) begin
          word_nxt = {word[WIDTH-2:0], bit_val};
          if (bcnt == BW'(WIDTH-1)) begin
            push_dat = {word[WIDTH-2:0], bit_val};
            if (space) begin
              push_req = 1'b1;
              word_nxt = '0;
              bcnt_nxt = '0;
            end else begin
              state_nxt = ST_HOLD;
            end
          end else begin
            bcnt_nxt = bcnt + BW'(1);
          end
        end
        ST_HOLD: begin
          // A stalled word keeps absorbing entropy until the FIFO drains.
          if (space) begin
            push_req  = 1'b1;
            word_nxt  = '0;
            bcnt_nxt  = '0;
            state_nxt = ST_FILL;
          end else if (bit_vld) begin
            word_nxt = {word[WIDTH-2:0], word[WIDTH-1] ^ bit_val};
          end
        end
        default: state_nxt = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || kill) begin
      state <= ST_FILL;
      word  <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      word  <= word_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

`ifdef TRNG_HEALTH_EN
  localparam int RW = $clog2(RCT_CUTOFF+1);
  logic [RW-1:0] run, run_nxt;
  logic          last;

  always_comb begin
    run_nxt = RW'(1);
    if (raw == last) run_nxt = (run == RW'(RCT_CUTOFF)) ? run : run + RW'(1);
  end

  assign alarm_set = i_enable & ~alarm & (run_nxt == RW'(RCT_CUTOFF));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      run   <= '0;
      last  <= 1'b0;
      alarm <= 1'b0;
    end else begin
      if (i_enable) begin
        run  <= run_nxt;
        last <= raw;
      end
      if (alarm_set) alarm <= 1'b1;
    end
  end
`else
  assign alarm_set = 1'b0;
  assign alarm     = 1'b0;
`endif

  assign kill    = alarm | alarm_set;
  assign o_alarm = alarm;

  trng_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (push_req & ~kill),
    .i_pop     (pop),
    .i_flush   (kill),
    .i_dat     (push_dat),
    .o_dat     (o_dat),
    .o_valid   (o_valid),
    .o_level   (o_level)
  );

endmodule

// File: tb/tb_trng_harvester.sv
// Bench for trng_harvester: DECIM=1 and DECIM=4 instances against a word-level model.
module tb_trng_harvester;
  localparam int SW  = 12;
  localparam int DEP = 4;
  localparam int CUT = 32;

  logic          clk = 1'b0;
  logic          rst_n, en, rd;
  logic [SW-1:0] src;
  logic [7:0]    o_dat     [2];
  logic          o_valid   [2];
  logic [2:0]    o_level   [2];
  logic [SW-1:0] o_sampled [2];
  logic          o_alarm   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trng_harvester #(.WIDTH(8), .NSRC(4), .SRC_WIDTH(3), .DECIM(1), .DEPTH(4), .RCT_CUTOFF(CUT)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_rnd_src(src), .i_enable(en), .i_read(rd),
    .o_dat(o_dat[0]), .o_valid(o_valid[0]), .o_level(o_level[0]),
    .o_sampled(o_sampled[0]), .o_alarm(o_alarm[0]));

  trng_harvester #(.WIDTH(8), .NSRC(4), .SRC_WIDTH(3), .DECIM(4), .DEPTH(4), .RCT_CUTOFF(CUT)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_rnd_src(src), .i_enable(en), .i_read(rd),
    .o_dat(o_dat[1]), .o_valid(o_valid[1]), .o_level(o_level[1]),
    .o_sampled(o_sampled[1]), .o_alarm(o_alarm[1]));

  // Reference model: raw bit stream, bit groups, word under construction, word queue.
  logic [SW-1:0] m_s1, m_samp;
  bit            m_raw;
  int            dn  [2];
  bit            dx  [2];
  logic [7:0]    wv  [2];
  int            wc  [2];
  bit            hd  [2];
  logic [7:0]    fm  [2][4];
  int            fn  [2];
  int            run [2];
  bit            last[2];
  bit            alm [2];

  task automatic model_step(input bit r, input bit e, input bit d, input logic [SW-1:0] s);
    bit rawv, b, nb, kill, space;
    int dec;
    rawv = m_raw;
    for (int m = 0; m < 2; m++) begin
      dec = (m == 0) ? 1 : 4;
      if (!r) begin
        dn[m] = 0; dx[m] = 0; wv[m] = 8'h00; wc[m] = 0; hd[m] = 0;
        fn[m] = 0; run[m] = 0; last[m] = 0; alm[m] = 0;
        continue;
      end
      kill = alm[m];
`ifdef TRNG_HEALTH_EN
      if (e && !alm[m]) begin
        if (run[m] == 0 || rawv != last[m]) run[m] = 1;
        else if (run[m] < CUT) run[m]++;
        last[m] = rawv;
        if (run[m] >= CUT) begin alm[m] = 1; kill = 1; end
      end
`endif
      if (kill) begin
        dn[m] = 0; dx[m] = 0; wv[m] = 8'h00; wc[m] = 0; hd[m] = 0; fn[m] = 0;
        continue;
      end
      if (d && fn[m] > 0) begin
        for (int i = 0; i < 3; i++) fm[m][i] = fm[m][i+1];
        fn[m]--;
      end
      space = (fn[m] < DEP);
      if (e) begin
        nb = 0; b = 0;
        dx[m] ^= rawv;
        dn[m]++;
        if (dn[m] == dec) begin nb = 1; b = dx[m]; dn[m] = 0; dx[m] = 0; end
        if (hd[m]) begin
          if (space) begin
            fm[m][fn[m]] = wv[m]; fn[m]++;
            hd[m] = 0; wv[m] = 8'h00; wc[m] = 0;
          end else if (nb) begin
            wv[m] = {wv[m][6:0], wv[m][7] ^ b};
          end
        end else if (nb) begin
          wv[m] = {wv[m][6:0], b};
          wc[m]++;
          if (wc[m] == 8) begin
            if (space) begin fm[m][fn[m]] = wv[m]; fn[m]++; wv[m] = 8'h00; wc[m] = 0; end
            else hd[m] = 1;
          end
        end
      end
    end
    if (!r) begin
      m_s1 = '0; m_samp = '0; m_raw = 0;
    end else begin
      m_raw  = ^m_samp;
      m_samp = m_s1;
      m_s1   = s;
    end
  endtask

  function automatic logic [SW-1:0] mk(input bit p);
    logic [SW-1:0] v;
    v = SW'($urandom);
    if ((^v) != p) v[0] = ~v[0];
    return v;
  endfunction

  task automatic cyc(input bit r, input bit e, input bit d, input logic [SW-1:0] s);
    rst_n = r; en = e; rd = d; src = s;
    model_step(r, e, d, s);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 30; k++) cyc(1'b1, 1'b1, k[2], SW'($urandom));
    cyc(1'b0, 1'b1, 1'b0, SW'($urandom));
    cyc(1'b0, 1'b1, 1'b1, SW'($urandom));
    for (int m = 0; m < 2; m++) begin
      total++; if (o_dat[m] !== 8'h00) begin bad++; $display("FAIL reset_dat[%0d]: got %h want 00", m, o_dat[m]); end
      total++; if (o_valid[m] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", m, o_valid[m]); end
      total++; if (o_level[m] !== 3'd0) begin bad++; $display("FAIL reset_level[%0d]: got %0d want 0", m, o_level[m]); end
      total++; if (o_sampled[m] !== '0) begin bad++; $display("FAIL reset_sampled[%0d]: got %h want 0", m, o_sampled[m]); end
      total++; if (o_alarm[m] !== 1'b0) begin bad++; $display("FAIL reset_alarm[%0d]: got %b want 0", m, o_alarm[m]); end
    end
  endtask

  task automatic test_alternating();
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    for (int k = 1; k <= 3; k++) cyc(1'b1, 1'b0, 1'b0, mk(k[0]));
    for (int k = 4; k <= 11; k++) begin
      cyc(1'b1, 1'b1, 1'b0, mk(k[0]));
      if (k == 10) begin
        total++; if (o_valid[0] !== 1'b0) begin bad++; $display("FAIL alt_early_valid: got %b want 0", o_valid[0]); end
      end
    end
    total++; if (o_valid[0] !== 1'b1) begin bad++; $display("FAIL alt_valid: got %b want 1", o_valid[0]); end
    total++; if (o_dat[0] !== 8'hAA) begin bad++; $display("FAIL alt_word: got %h want aa", o_dat[0]); end
  endtask

  task automatic test_saturate_hold();
    logic [7:0] nxt;
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 48; k++) cyc(1'b1, 1'b1, 1'b0, SW'($urandom));
    total++; if (o_level[0] !== 3'd4) begin bad++; $display("FAIL sat_level: got %0d want 4", o_level[0]); end
    total++; if (o_valid[0] !== 1'b1) begin bad++; $display("FAIL sat_valid: got %b want 1", o_valid[0]); end
    total++; if (hd[0] !== 1'b1 || o_dat[0] !== fm[0][0]) begin bad++; $display("FAIL sat_head: got %h want %h", o_dat[0], fm[0][0]); end
    nxt = fm[0][1];
    cyc(1'b1, 1'b1, 1'b1, SW'($urandom));
    total++; if (o_level[0] !== 3'd4) begin bad++; $display("FAIL hold_pop_level: got %0d want 4", o_level[0]); end
    total++; if (o_dat[0] !== nxt) begin bad++; $display("FAIL hold_pop_head: got %h want %h", o_dat[0], nxt); end
  endtask

  task automatic test_decim4();
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    for (int k = 1; k <= 35; k++) begin
      cyc(1'b1, k >= 4, 1'b0, mk(((k-1) % 4) != 3));
      if (k == 34) begin
        total++; if (o_valid[1] !== 1'b0) begin bad++; $display("FAIL dec4_early_valid: got %b want 0", o_valid[1]); end
      end
    end
    total++; if (o_valid[1] !== 1'b1 || o_dat[1] !== 8'hFF) begin bad++; $display("FAIL dec4_word: got %h want ff", o_dat[1]); end
    total++; if (o_dat[0] !== 8'hEE) begin bad++; $display("FAIL dec1_pattern_word: got %h want ee", o_dat[0]); end
  endtask

  task automatic test_enable_freeze();
    logic [2:0] lv0, lv1;
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 13; k++) cyc(1'b1, 1'b1, 1'b0, SW'($urandom));
    lv0 = o_level[0]; lv1 = o_level[1];
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b0, 1'b0, SW'($urandom));
      total++; if (o_level[0] !== lv0 || o_level[1] !== lv1) begin
        bad++; $display("FAIL freeze_level: got %0d/%0d want %0d/%0d", o_level[0], o_level[1], lv0, lv1);
      end
    end
    for (int k = 0; k < 40; k++) cyc(1'b1, 1'b1, 1'b0, SW'($urandom));
    for (int m = 0; m < 2; m++) begin
      total++; if (o_level[m] !== 3'(fn[m]) || o_dat[m] !== ((fn[m] > 0) ? fm[m][0] : 8'h00)) begin
        bad++; $display("FAIL resume[%0d]: got %0d/%h want %0d/%h", m, o_level[m], o_dat[m], fn[m], fm[m][0]);
      end
    end
  endtask

`ifdef TRNG_HEALTH_EN
  task automatic test_health();
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    for (int e = 1; e <= 40; e++) begin
      cyc(1'b1, 1'b1, 1'b0, mk(1'b0));
      if (e == 31 || e == 32 || e == 40) begin
        for (int m = 0; m < 2; m++) begin
          total++; if (o_alarm[m] !== (e >= 32)) begin bad++; $display("FAIL rct_alarm[%0d] e=%0d: got %b want %b", m, e, o_alarm[m], e >= 32); end
        end
      end
    end
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, k[0], SW'($urandom));
    for (int m = 0; m < 2; m++) begin
      total++; if (o_valid[m] !== 1'b0 || o_level[m] !== 3'd0) begin
        bad++; $display("FAIL rct_flush[%0d]: got valid=%b level=%0d want 0/0", m, o_valid[m], o_level[m]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(63) != 0, $urandom_range(9) < 8, $urandom_range(1) == 1, SW'($urandom));
      total++; if (o_sampled[0] !== m_samp) begin bad++; $display("FAIL rnd_sampled c%0d: got %h want %h", k, o_sampled[0], m_samp); end
      for (int m = 0; m < 2; m++) begin
        total++; if (o_dat[m] !== ((fn[m] > 0) ? fm[m][0] : 8'h00)) begin bad++; $display("FAIL rnd_dat[%0d] c%0d: got %h want %h", m, k, o_dat[m], (fn[m] > 0) ? fm[m][0] : 8'h00); end
        total++; if (o_valid[m] !== (fn[m] > 0)) begin bad++; $display("FAIL rnd_valid[%0d] c%0d: got %b want %b", m, k, o_valid[m], fn[m] > 0); end
        total++; if (o_level[m] !== 3'(fn[m])) begin bad++; $display("FAIL rnd_level[%0d] c%0d: got %0d want %0d", m, k, o_level[m], fn[m]); end
        total++; if (o_alarm[m] !== alm[m]) begin bad++; $display("FAIL rnd_alarm[%0d] c%0d: got %b want %b", m, k, o_alarm[m], alm[m]); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rd = 1'b0; src = '0;
    test_reset();
    test_alternating();
    test_saturate_hold();
    test_decim4();
    test_enable_freeze();
`ifdef TRNG_HEALTH_EN
    test_health();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
